// File: rtl/adc_resp_pkg.sv
// adc_resp_pkg: shared types and constants for the
// MCP3002-style SPI ADC responder.
package adc_resp_pkg;

  localparam int ADC_BITS = 10;
  localparam int CMD_BITS = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_START,
    ST_CMD,
    ST_NULL,
    ST_DATA,
    ST_LSBF,
    ST_TAIL
  } state_e;

endpackage

// File: rtl/adc_spi_responder_pin_sync_edge.sv
// pin_sync_edge: multi-flop synchronizer for one async pin
// plus registered rise/fall pulses of the synchronized level.
module pin_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;
  logic              rise_q;
  logic              fall_q;

  // synchronize the pin, then compare with the previous level
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], pin_i};
      prev_q <= sync_q[STAGES-1];
      rise_q <= sync_q[STAGES-1] & ~prev_q;
      fall_q <= ~sync_q[STAGES-1] & prev_q;
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/adc_spi_responder.sv
// adc_spi_responder: stands in for an MCP3002 ADC on the SPI pins.
// Define ADC_RESP_LSBF_EN to add the LSB-first tail (MSBF=0 frames).
module adc_spi_responder
  import adc_resp_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                sysclk,
  input  logic                reset,
  input  logic                adc_cs,
  input  logic                adc_sck,
  input  logic                sdata_to_adc,
  input  logic [ADC_BITS-1:0] sample_ch0,
  input  logic [ADC_BITS-1:0] sample_ch1,
  output logic                sdata_from_adc,
  output logic                busy,
  output logic                conv_done,
  output logic                conv_channel,
  output logic                cmd_error
);

  localparam logic [3:0] LAST = 4'(ADC_BITS - 1);

  logic cs_s, cs_rise, cs_fall;
  logic sck_s, sck_rise, sck_fall;

  logic [SYNC_STAGES-1:0] sdi_sync_q;
  logic                   sdi_q;
  logic [SYNC_STAGES-1:0] warm_q;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADC_BITS-1:0] sr_q, sr_d;
  logic                odd_q, odd_d;
  logic                sdo_q, sdo_d;
  logic                done_q, done_d;
  logic                chan_q, chan_d;
  logic                err_q, err_d;
  logic                armed_q, armed_d;
`ifdef ADC_RESP_LSBF_EN
  logic                msbf_q, msbf_d;
`endif

  pin_sync_edge #(
    .STAGES (SYNC_STAGES),
    .RST_VAL(1'b1)
  ) u_cs_sync (
    .clk_i  (sysclk),
    .rst_i  (reset),
    .pin_i  (adc_cs),
    .level_o(cs_s),
    .rise_o (cs_rise),
    .fall_o (cs_fall)
  );

  pin_sync_edge #(
    .STAGES (SYNC_STAGES),
    .RST_VAL(1'b0)
  ) u_sck_sync (
    .clk_i  (sysclk),
    .rst_i  (reset),
    .pin_i  (adc_sck),
    .level_o(sck_s),
    .rise_o (sck_rise),
    .fall_o (sck_fall)
  );

  // CS edges and SCK level are not needed by the FSM
  logic unused_pins;
  assign unused_pins = &{1'b0, cs_rise, cs_fall, sck_s};

  // SDI synchronizer, delayed one extra flop to line up with SCK pulses;
  // warm_q marks when the CS synchronizer holds real pin samples
  always_ff @(posedge sysclk) begin
    if (reset) begin
      sdi_sync_q <= '0;
      sdi_q      <= 1'b0;
      warm_q     <= '0;
    end else begin
      sdi_sync_q <= {sdi_sync_q[SYNC_STAGES-2:0], sdata_to_adc};
      sdi_q      <= sdi_sync_q[SYNC_STAGES-1];
      warm_q     <= {warm_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // protocol FSM: next state, shift index and pin outputs
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    odd_d   = odd_q;
    sdo_d   = sdo_q;
    done_d  = 1'b0;
    chan_d  = chan_q;
    err_d   = err_q;
    armed_d = armed_q | (cs_s & warm_q[SYNC_STAGES-1]);
`ifdef ADC_RESP_LSBF_EN
    msbf_d  = msbf_q;
`endif
    if (cs_s) begin
      state_d = ST_IDLE;
      sdo_d   = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          sdo_d = 1'b1;
          if (armed_q) begin
            state_d = ST_WAIT_START;
          end
        end
        ST_WAIT_START: begin
          if (sck_rise && sdi_q) begin
            state_d = ST_CMD;
            cnt_d   = 4'd0;
          end
        end
        ST_CMD: begin
          if (sck_rise) begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd0) begin
              if (!sdi_q) err_d = 1'b1;
            end else if (cnt_q == 4'd1) begin
              odd_d = sdi_q;
            end else begin
`ifdef ADC_RESP_LSBF_EN
              msbf_d  = sdi_q;
`endif
              sr_d    = odd_q ? sample_ch1 : sample_ch0;
              state_d = ST_NULL;
            end
          end
        end
        ST_NULL: begin
          if (sck_fall) begin
            sdo_d   = 1'b0;
            cnt_d   = 4'd0;
            state_d = ST_DATA;
          end
        end
        ST_DATA: begin
          if (sck_fall) begin
            sdo_d = sr_q[LAST - cnt_q];
            if (cnt_q == LAST) begin
              done_d = 1'b1;
              chan_d = odd_q;
              cnt_d  = 4'd0;
`ifdef ADC_RESP_LSBF_EN
              state_d = msbf_q ? ST_TAIL : ST_LSBF;
`else
              state_d = ST_TAIL;
`endif
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end
        end
        ST_LSBF: begin
          if (sck_fall) begin
            sdo_d = sr_q[cnt_q + 4'd1];
            if (cnt_q == LAST - 4'd1) begin
              state_d = ST_TAIL;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end
        end
        ST_TAIL: begin
          if (sck_fall) sdo_d = 1'b0;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // FSM and datapath registers
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      sr_q    <= '0;
      odd_q   <= 1'b0;
      sdo_q   <= 1'b1;
      done_q  <= 1'b0;
      chan_q  <= 1'b0;
      err_q   <= 1'b0;
      armed_q <= 1'b0;
`ifdef ADC_RESP_LSBF_EN
      msbf_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      odd_q   <= odd_d;
      sdo_q   <= sdo_d;
      done_q  <= done_d;
      chan_q  <= chan_d;
      err_q   <= err_d;
      armed_q <= armed_d;
`ifdef ADC_RESP_LSBF_EN
      msbf_q  <= msbf_d;
`endif
    end
  end

  assign sdata_from_adc = sdo_q;
  assign busy           = (state_q != ST_IDLE);
  assign conv_done      = done_q;
  assign conv_channel   = chan_q;
  assign cmd_error      = err_q;

endmodule

// File: tb/tb_adc_spi_responder.sv
// tb_adc_spi_responder: directed SPI frames against adc_spi_responder
// with hand-computed response words.
module tb_adc_spi_responder;

  localparam int H = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cs  = 1'b1;
  logic       sck = 1'b0;
  logic       sdi = 1'b0;
  logic [9:0] ch0 = '0;
  logic [9:0] ch1 = '0;
  logic       sdo, busy, done, chan, err;

  int tests_run = 0;
  int fails     = 0;
  int done_cnt  = 0;
  int chg_at    = -1;
  logic [9:0] chg_val = '0;

  adc_spi_responder #(
    .SYNC_STAGES(2)
  ) dut (
    .sysclk        (clk),
    .reset         (rst),
    .adc_cs        (cs),
    .adc_sck       (sck),
    .sdata_to_adc  (sdi),
    .sample_ch0    (ch0),
    .sample_ch1    (ch1),
    .sdata_from_adc(sdo),
    .busy          (busy),
    .conv_done     (done),
    .conv_channel  (chan),
    .cmd_error     (err)
  );

  always #10 clk = ~clk;

  always @(posedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
  end

  // n SCK clocks with CS low; rx bit n-1-k is SDO seen after fall k+1
  task automatic frame(input logic [31:0] cmd, input int n,
                       output logic [31:0] rx);
    rx  = '0;
    cs  = 1'b0;
    sdi = cmd[n-1];
    repeat (H) @(negedge clk);
    for (int k = 0; k < n; k++) begin
      sck = 1'b1;
      repeat (H) @(negedge clk);
      sck = 1'b0;
      if (k == chg_at) ch0 = chg_val;
      repeat (H/2) @(negedge clk);
      sdi = (k + 1 < n) ? cmd[n-2-k] : 1'b0;
      repeat (H/2) @(negedge clk);
      rx[n-1-k] = sdo;
    end
  endtask

  task automatic cs_high();
    cs  = 1'b1;
    sdi = 1'b0;
    repeat (H) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if (sdo !== 1'b1) begin
      fails++; $display("FAIL reset_sdo got %b exp 1", sdo);
    end
    tests_run++;
    if (busy !== 1'b0) begin
      fails++; $display("FAIL reset_busy got %b exp 0", busy);
    end
    tests_run++;
    if (done !== 1'b0) begin
      fails++; $display("FAIL reset_done got %b exp 0", done);
    end
    tests_run++;
    if (chan !== 1'b0) begin
      fails++; $display("FAIL reset_chan got %b exp 0", chan);
    end
    tests_run++;
    if (err !== 1'b0) begin
      fails++; $display("FAIL reset_err got %b exp 0", err);
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_busy_timing();
    cs = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if (busy !== 1'b0) begin
      fails++; $display("FAIL busy_early got %b exp 0", busy);
    end
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b1) begin
      fails++; $display("FAIL busy_rise got %b exp 1", busy);
    end
    cs_high();
  endtask

  task automatic test_basic();
    logic [31:0] rx;
    int d0;
    ch0 = 10'h2A5;
    d0  = done_cnt;
    frame(32'hD000, 16, rx);
    tests_run++;
    if (rx[15:0] !== 16'hEA94) begin
      fails++; $display("FAIL basic_rx got %h exp ea94", rx[15:0]);
    end
    tests_run++;
    if (busy !== 1'b1) begin
      fails++; $display("FAIL basic_busy got %b exp 1", busy);
    end
    cs_high();
    tests_run++;
    if (done_cnt - d0 !== 1) begin
      fails++; $display("FAIL basic_done got %0d exp 1", done_cnt - d0);
    end
    tests_run++;
    if (chan !== 1'b0) begin
      fails++; $display("FAIL basic_chan got %b exp 0", chan);
    end
  endtask

  task automatic test_channel();
    logic [31:0] rx;
    int d0;
    ch0 = 10'h000;
    ch1 = 10'h3FF;
    d0  = done_cnt;
    frame(32'hF000, 16, rx);
    cs_high();
    tests_run++;
    if (rx[15:0] !== 16'hEFFC) begin
      fails++; $display("FAIL chan_rx got %h exp effc", rx[15:0]);
    end
    tests_run++;
    if (chan !== 1'b1) begin
      fails++; $display("FAIL chan_sel got %b exp 1", chan);
    end
    tests_run++;
    if (done_cnt - d0 !== 1) begin
      fails++; $display("FAIL chan_done got %0d exp 1", done_cnt - d0);
    end
  endtask

  task automatic test_leading_zeros();
    logic [31:0] rx;
    ch0 = 10'h2A5;
    frame(32'h0D000, 18, rx);
    cs_high();
    tests_run++;
    if (rx[17:0] !== 18'h3EA94) begin
      fails++; $display("FAIL lead0_rx got %h exp 3ea94", rx[17:0]);
    end
    tests_run++;
    if (chan !== 1'b0) begin
      fails++; $display("FAIL lead0_chan got %b exp 0", chan);
    end
  endtask

  task automatic test_abort();
    logic [31:0] rx;
    int d0;
    ch0 = 10'h2A5;
    d0  = done_cnt;
    frame(32'hD0, 8, rx);
    tests_run++;
    if (rx[7:0] !== 8'hEA) begin
      fails++; $display("FAIL abort_rx got %h exp ea", rx[7:0]);
    end
    cs = 1'b1;
    repeat (4) @(negedge clk);
    tests_run++;
    if (sdo !== 1'b1) begin
      fails++; $display("FAIL abort_sdo got %b exp 1", sdo);
    end
    tests_run++;
    if (busy !== 1'b0) begin
      fails++; $display("FAIL abort_busy got %b exp 0", busy);
    end
    cs_high();
    tests_run++;
    if (done_cnt !== d0) begin
      fails++; $display("FAIL abort_done got %0d exp %0d", done_cnt, d0);
    end
    ch0 = 10'h155;
    frame(32'hD000, 16, rx);
    cs_high();
    tests_run++;
    if (rx[15:0] !== 16'hE554) begin
      fails++; $display("FAIL abort_next got %h exp e554", rx[15:0]);
    end
    tests_run++;
    if (done_cnt - d0 !== 1) begin
      fails++; $display("FAIL abort_next_done got %0d exp 1", done_cnt - d0);
    end
  endtask

  task automatic test_freeze();
    logic [31:0] rx;
    ch0     = 10'h2A5;
    chg_at  = 4;
    chg_val = 10'h0F0;
    frame(32'hD000, 16, rx);
    cs_high();
    chg_at  = -1;
    tests_run++;
    if (rx[15:0] !== 16'hEA94) begin
      fails++; $display("FAIL freeze_rx got %h exp ea94", rx[15:0]);
    end
  endtask

  task automatic test_cmd_error();
    logic [31:0] rx;
    tests_run++;
    if (err !== 1'b0) begin
      fails++; $display("FAIL err_pre got %b exp 0", err);
    end
    ch1 = 10'h3FF;
    frame(32'hB000, 16, rx);
    cs_high();
    tests_run++;
    if (rx[15:0] !== 16'hEFFC) begin
      fails++; $display("FAIL err_rx got %h exp effc", rx[15:0]);
    end
    tests_run++;
    if (err !== 1'b1) begin
      fails++; $display("FAIL err_set got %b exp 1", err);
    end
    ch0 = 10'h2A5;
    frame(32'hD000, 16, rx);
    cs_high();
    tests_run++;
    if (err !== 1'b1) begin
      fails++; $display("FAIL err_sticky got %b exp 1", err);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    tests_run++;
    if (err !== 1'b0) begin
      fails++; $display("FAIL err_clear got %b exp 0", err);
    end
  endtask

  task automatic test_lsbf();
    logic [31:0] rx;
    logic [25:0] exp2;
    int d0;
    ch0 = 10'h001;
    d0  = done_cnt;
    frame(32'h3000000, 26, rx);
    cs_high();
    tests_run++;
    if (rx[25:0] !== 26'h3801000) begin
      fails++; $display("FAIL lsbf1_rx got %h exp 3801000", rx[25:0]);
    end
    ch0 = 10'h2A5;
`ifdef ADC_RESP_LSBF_EN
    exp2 = 26'h3AA54A8;
`else
    exp2 = 26'h3AA5000;
`endif
    frame(32'h3000000, 26, rx);
    cs_high();
    tests_run++;
    if (rx[25:0] !== exp2) begin
      fails++; $display("FAIL lsbf2_rx got %h exp %h", rx[25:0], exp2);
    end
    tests_run++;
    if (done_cnt - d0 !== 2) begin
      fails++; $display("FAIL lsbf_done got %0d exp 2", done_cnt - d0);
    end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] rx;
    int d0;
    ch0 = 10'h2A5;
    d0  = done_cnt;
    frame(32'h34, 6, rx);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (sdo !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL rstmid_pins got %b%b exp 10", sdo, busy);
    end
    frame(32'hD000, 16, rx);
    tests_run++;
    if (rx[15:0] !== 16'hFFFF) begin
      fails++; $display("FAIL rstmid_rx got %h exp ffff", rx[15:0]);
    end
    tests_run++;
    if (busy !== 1'b0) begin
      fails++; $display("FAIL rstmid_busy got %b exp 0", busy);
    end
    cs_high();
    tests_run++;
    if (done_cnt !== d0) begin
      fails++; $display("FAIL rstmid_done got %0d exp %0d", done_cnt, d0);
    end
    frame(32'hD000, 16, rx);
    cs_high();
    tests_run++;
    if (rx[15:0] !== 16'hEA94) begin
      fails++; $display("FAIL rstmid_next got %h exp ea94", rx[15:0]);
    end
  endtask

  initial begin
    test_reset();
    test_busy_timing();
    test_basic();
    test_channel();
    test_leading_zeros();
    test_abort();
    test_freeze();
    test_cmd_error();
    test_lsbf();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
